// File: rtl/seg7_monitor_if.sv
// Seven-segment monitor bus: segment input and clear request toward the monitor,
// decoded digit, period and status back from it.
// With SEG7_MON_MINMAX_EN defined the bus also carries PERIOD_MIN / PERIOD_MAX.
interface seg7_monitor_if;
  logic [7:0]  SEG_IN;
  logic        CLR_ERR;
  logic [3:0]  DIGIT;
  logic        DIGIT_VALID;
  logic        NEW_DIGIT;
  logic [31:0] PERIOD;
  logic        CODE_ERR;
  logic        SEQ_ERR;
  logic        TIMING_ERR;
  logic        LOCKED;
`ifdef SEG7_MON_MINMAX_EN
  logic [31:0] PERIOD_MIN;
  logic [31:0] PERIOD_MAX;

  modport master (
    output SEG_IN, CLR_ERR,
    input  DIGIT, DIGIT_VALID, NEW_DIGIT, PERIOD, CODE_ERR, SEQ_ERR, TIMING_ERR, LOCKED,
    input  PERIOD_MIN, PERIOD_MAX
  );

  modport slave (
    input  SEG_IN, CLR_ERR,
    output DIGIT, DIGIT_VALID, NEW_DIGIT, PERIOD, CODE_ERR, SEQ_ERR, TIMING_ERR, LOCKED,
    output PERIOD_MIN, PERIOD_MAX
  );
`else
  modport master (
    output SEG_IN, CLR_ERR,
    input  DIGIT, DIGIT_VALID, NEW_DIGIT, PERIOD, CODE_ERR, SEQ_ERR, TIMING_ERR, LOCKED
  );

  modport slave (
    input  SEG_IN, CLR_ERR,
    output DIGIT, DIGIT_VALID, NEW_DIGIT, PERIOD, CODE_ERR, SEQ_ERR, TIMING_ERR, LOCKED
  );
`endif
endinterface

// File: rtl/seg7_monitor.sv
// Receive-side checker for a 1 Hz hex-counter seven-segment bus.
// Synchronises and glitch-filters SEG_IN, decodes it back to a hex digit, measures the
// cycle count between accepted changes and raises sticky code/sequence/timing flags.
// Optional feature: define SEG7_MON_MINMAX_EN to add PERIOD_MIN / PERIOD_MAX tracking.
module seg7_monitor #(
  parameter int unsigned CLK_FREQ   = 125_000_000,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned STABLE_CYC = 8
) (
  input  logic         CLK,
  input  logic         RST,
  seg7_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StTrack
  } state_e;

  localparam int unsigned      FiltW    = $clog2(STABLE_CYC + 1);
  localparam logic [FiltW-1:0] FiltFull = FiltW'(STABLE_CYC);
  localparam logic [31:0]      PerLo    = 32'(CLK_FREQ - TOL);
  localparam logic [31:0]      PerHi    = 32'(CLK_FREQ + TOL);
  localparam logic [31:0]      PerTmo   = PerHi + 32'd1;

  // Returns {legal, digit}; dp must be off for a legal code.
  function automatic logic [4:0] seg_decode(input logic [7:0] pat);
    logic [4:0] res;
    case (pat)
      8'h3F:   res = {1'b1, 4'h0};
      8'h06:   res = {1'b1, 4'h1};
      8'h5B:   res = {1'b1, 4'h2};
      8'h4F:   res = {1'b1, 4'h3};
      8'h66:   res = {1'b1, 4'h4};
      8'h6D:   res = {1'b1, 4'h5};
      8'h7D:   res = {1'b1, 4'h6};
      8'h27:   res = {1'b1, 4'h7};
      8'h7F:   res = {1'b1, 4'h8};
      8'h6F:   res = {1'b1, 4'h9};
      8'h77:   res = {1'b1, 4'hA};
      8'h7C:   res = {1'b1, 4'hB};
      8'h39:   res = {1'b1, 4'hC};
      8'h5E:   res = {1'b1, 4'hD};
      8'h79:   res = {1'b1, 4'hE};
      8'h71:   res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // Input path registers
  logic [7:0]       r_sync1;
  logic [7:0]       r_sync2;
  logic [7:0]       r_cand;
  logic [7:0]       r_acc;
  logic [FiltW-1:0] r_filt_cnt;
  logic [FiltW-1:0] w_filt_nxt;
  logic             w_accept;
  logic [4:0]       w_dec;

  // Measurement / status registers
  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_digit;
  logic [3:0]  w_digit_nxt;
  logic        r_digit_valid;
  logic        w_digit_valid_nxt;
  logic        r_new_digit;
  logic        w_new_digit_nxt;
  logic [31:0] r_period;
  logic [31:0] w_period_nxt;
  logic [31:0] r_per_cnt;
  logic [31:0] w_per_cnt_nxt;
  logic        r_code_err;
  logic        w_code_err_nxt;
  logic        r_seq_err;
  logic        w_seq_err_nxt;
  logic        r_timing_err;
  logic        w_timing_err_nxt;
  logic        r_locked;
  logic        w_locked_nxt;
  logic [1:0]  r_good;
  logic [1:0]  w_good_nxt;
  logic        w_code_new;
  logic        w_seq_new;
  logic        w_tim_new;
  logic        w_meas;

  // Count consecutive identical synchronised samples; a change of candidate restarts at one.
  always_comb begin
    if (r_sync2 != r_cand) begin
      w_filt_nxt = FiltW'(1);
    end else if (r_filt_cnt == FiltFull) begin
      w_filt_nxt = FiltFull;
    end else begin
      w_filt_nxt = r_filt_cnt + FiltW'(1);
    end
  end

  // Only a stable pattern that differs from the accepted one is an event.
  assign w_accept = (w_filt_nxt == FiltFull) && (r_sync2 != r_acc);
  assign w_dec    = seg_decode(r_sync2);

  // Two-flop synchroniser followed by the stability filter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1    <= 8'h00;
      r_sync2    <= 8'h00;
      r_cand     <= 8'h00;
      r_acc      <= 8'h00;
      r_filt_cnt <= '0;
    end else begin
      r_sync1    <= mon.SEG_IN;
      r_sync2    <= r_sync1;
      r_cand     <= r_sync2;
      r_filt_cnt <= w_filt_nxt;
      if (w_accept) begin
        r_acc <= r_sync2;
      end
    end
  end

  // Next-state: FSM, period measurement, checks and sticky flags.
  always_comb begin
    w_state_nxt       = r_state;
    w_digit_nxt       = r_digit;
    w_digit_valid_nxt = r_digit_valid;
    w_new_digit_nxt   = 1'b0;
    w_period_nxt      = r_period;
    w_per_cnt_nxt     = r_per_cnt;
    w_locked_nxt      = r_locked;
    w_good_nxt        = r_good;
    w_code_new        = 1'b0;
    w_seq_new         = 1'b0;
    w_tim_new         = 1'b0;
    w_meas            = 1'b0;

    // Cycle counter runs, saturating, only while a reference accept exists.
    if ((r_state != StIdle) && (r_per_cnt != 32'hFFFF_FFFF)) begin
      w_per_cnt_nxt = r_per_cnt + 32'd1;
    end

    if (w_accept) begin
      w_new_digit_nxt = 1'b1;
      if (!w_dec[4]) begin
        w_code_new        = 1'b1;
        w_digit_valid_nxt = 1'b0;
        w_state_nxt       = StIdle;
        w_per_cnt_nxt     = '0;
      end else begin
        w_digit_nxt       = w_dec[3:0];
        w_digit_valid_nxt = 1'b1;
        // Loaded with one so that its value at the next accept equals t1 - t0.
        w_per_cnt_nxt     = 32'd1;
        if (r_state == StIdle) begin
          w_state_nxt = StArmed;
        end else begin
          w_state_nxt  = StTrack;
          w_period_nxt = r_per_cnt;
          w_meas       = 1'b1;
          w_seq_new    = (w_dec[3:0] != (r_digit + 4'd1));
          w_tim_new    = (r_per_cnt < PerLo) || (r_per_cnt > PerHi);
        end
      end
    end else if ((r_state != StIdle) && (r_per_cnt == PerTmo)) begin
      // Counter passes this value once per period, so the timeout fires once.
      w_tim_new = 1'b1;
    end

    if (w_code_new || w_seq_new || w_tim_new) begin
      w_good_nxt   = 2'd0;
      w_locked_nxt = 1'b0;
    end else if (w_meas) begin
      if (r_good != 2'd2) begin
        w_good_nxt = r_good + 2'd1;
      end
      if (r_good != 2'd0) begin
        w_locked_nxt = 1'b1;
      end
    end

    // A new error in the clearing cycle wins.
    w_code_err_nxt   = (r_code_err   & ~mon.CLR_ERR) | w_code_new;
    w_seq_err_nxt    = (r_seq_err    & ~mon.CLR_ERR) | w_seq_new;
    w_timing_err_nxt = (r_timing_err & ~mon.CLR_ERR) | w_tim_new;
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= StIdle;
      r_digit       <= 4'h0;
      r_digit_valid <= 1'b0;
      r_new_digit   <= 1'b0;
      r_period      <= '0;
      r_per_cnt     <= '0;
      r_code_err    <= 1'b0;
      r_seq_err     <= 1'b0;
      r_timing_err  <= 1'b0;
      r_locked      <= 1'b0;
      r_good        <= 2'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_digit       <= w_digit_nxt;
      r_digit_valid <= w_digit_valid_nxt;
      r_new_digit   <= w_new_digit_nxt;
      r_period      <= w_period_nxt;
      r_per_cnt     <= w_per_cnt_nxt;
      r_code_err    <= w_code_err_nxt;
      r_seq_err     <= w_seq_err_nxt;
      r_timing_err  <= w_timing_err_nxt;
      r_locked      <= w_locked_nxt;
      r_good        <= w_good_nxt;
    end
  end

  assign mon.DIGIT       = r_digit;
  assign mon.DIGIT_VALID = r_digit_valid;
  assign mon.NEW_DIGIT   = r_new_digit;
  assign mon.PERIOD      = r_period;
  assign mon.CODE_ERR    = r_code_err;
  assign mon.SEQ_ERR     = r_seq_err;
  assign mon.TIMING_ERR  = r_timing_err;
  assign mon.LOCKED      = r_locked;

`ifdef SEG7_MON_MINMAX_EN
  logic [31:0] r_per_min;
  logic [31:0] r_per_max;
  logic [31:0] w_min_base;
  logic [31:0] w_max_base;
  logic [31:0] w_per_min_nxt;
  logic [31:0] w_per_max_nxt;

  // Fold each measured period into the running extremes; CLR_ERR restarts them first.
  always_comb begin
    w_min_base    = mon.CLR_ERR ? 32'hFFFF_FFFF : r_per_min;
    w_max_base    = mon.CLR_ERR ? 32'h0000_0000 : r_per_max;
    w_per_min_nxt = w_min_base;
    w_per_max_nxt = w_max_base;
    if (w_meas) begin
      if (r_per_cnt < w_min_base) begin
        w_per_min_nxt = r_per_cnt;
      end
      if (r_per_cnt > w_max_base) begin
        w_per_max_nxt = r_per_cnt;
      end
    end
  end

  // Min/max registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_per_min <= 32'hFFFF_FFFF;
      r_per_max <= 32'h0000_0000;
    end else begin
      r_per_min <= w_per_min_nxt;
      r_per_max <= w_per_max_nxt;
    end
  end

  assign mon.PERIOD_MIN = r_per_min;
  assign mon.PERIOD_MAX = r_per_max;
`else
  // Period extremes are not tracked in this build.
`endif

endmodule

// File: tb/tb_seg7_monitor.sv
// Bench for seg7_monitor: vector table, hand-written corner sequences and random
// stimulus, all checked every cycle against a timestamp/window reference model.
module tb_seg7_monitor;
  localparam int unsigned CLK_FREQ   = 100;
  localparam int unsigned TOL        = 2;
  localparam int unsigned STABLE_CYC = 4;
  localparam int          PER_LO     = CLK_FREQ - TOL;
  localparam int          PER_HI     = CLK_FREQ + TOL;
  localparam int          PER_TMO    = PER_HI + 1;
  localparam int          LATENCY    = 2 + STABLE_CYC;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  seg7_monitor_if mon ();

  seg7_monitor #(
    .CLK_FREQ  (CLK_FREQ),
    .TOL       (TOL),
    .STABLE_CYC(STABLE_CYC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .mon(mon)
  );

  always #5 CLK = ~CLK;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h27,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_hist [$];
  logic [7:0]  m_acc;
  bit          m_active;
  int          m_now = 0;
  int          m_t_last;
  int          m_good;
  logic [3:0]  e_digit;
  logic        e_valid, e_new, e_code, e_seq, e_tim, e_locked;
  logic [31:0] e_period, e_min, e_max;

  task automatic model_edge(input logic [7:0] seg, input logic clr, input logic rst);
    int   base, dig, p;
    bit   stable, n_code, n_seq, n_tim;
    logic [7:0] v;
    m_now++;
    if (rst) begin
      m_hist.delete();
      repeat (STABLE_CYC + 2) m_hist.push_back(8'h00);
      m_acc = 8'h00; m_active = 0; m_good = 0;
      e_digit = 0; e_valid = 0; e_new = 0; e_period = 0;
      e_code = 0; e_seq = 0; e_tim = 0; e_locked = 0;
      e_min = 32'hFFFF_FFFF; e_max = 0;
      return;
    end
    m_hist.push_back(seg);
    if (m_hist.size() > STABLE_CYC + 3) void'(m_hist.pop_front());
    // The filter sees the input two edges late; accept needs STABLE_CYC equal samples.
    base = m_hist.size() - 3;
    v = m_hist[base];
    stable = 1;
    for (int k = 1; k < STABLE_CYC; k++) if (m_hist[base - k] != v) stable = 0;
    n_code = 0; n_seq = 0; n_tim = 0;
    e_new = 0;
    if (clr) begin
      e_min = 32'hFFFF_FFFF;
      e_max = 0;
    end
    if (stable && v != m_acc) begin
      m_acc = v;
      e_new = 1;
      dig = -1;
      for (int d = 0; d < 16; d++) if (seg_tab[d] == v) dig = d;
      if (dig < 0) begin
        n_code = 1; e_valid = 0; m_active = 0;
      end else if (!m_active) begin
        e_digit = 4'(dig); e_valid = 1; m_active = 1; m_t_last = m_now;
      end else begin
        p = m_now - m_t_last;
        m_t_last = m_now;
        e_period = 32'(p);
        n_seq = (dig != (int'(e_digit) + 1) % 16);
        n_tim = (p < PER_LO) || (p > PER_HI);
        if (32'(p) < e_min) e_min = 32'(p);
        if (32'(p) > e_max) e_max = 32'(p);
        e_digit = 4'(dig); e_valid = 1;
        if (!n_seq && !n_tim) begin
          m_good++;
          if (m_good >= 2) e_locked = 1;
        end
      end
    end else if (m_active && (m_now - m_t_last == PER_TMO)) begin
      n_tim = 1;
    end
    if (n_code || n_seq || n_tim) begin
      m_good = 0;
      e_locked = 0;
    end
    e_code = (e_code & ~clr) | n_code;
    e_seq  = (e_seq  & ~clr) | n_seq;
    e_tim  = (e_tim  & ~clr) | n_tim;
  endtask

  function automatic logic [63:0] outs();
    return 64'({mon.DIGIT, mon.DIGIT_VALID, mon.NEW_DIGIT, mon.PERIOD,
                mon.CODE_ERR, mon.SEQ_ERR, mon.TIMING_ERR, mon.LOCKED});
  endfunction

  task automatic tick(input logic [7:0] seg, input logic clr, input logic rst);
    mon.SEG_IN  = seg;
    mon.CLR_ERR = clr;
    RST         = rst;
    @(posedge CLK);
    model_edge(seg, clr, rst);
    #1;
    chk($sformatf("cycle%0d outputs", m_now), outs(),
        64'({e_digit, e_valid, e_new, e_period, e_code, e_seq, e_tim, e_locked}));
`ifdef SEG7_MON_MINMAX_EN
    chk($sformatf("cycle%0d minmax", m_now), {mon.PERIOD_MIN, mon.PERIOD_MAX}, {e_min, e_max});
`endif
  endtask

  task automatic hold(input logic [7:0] seg, input int n);
    for (int t = 0; t < n; t++) tick(seg, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(8'h00, 1'b0, 1'b1);
    tick(8'h00, 1'b0, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  seg;
    int          hold;
    logic        clr;
    logic [3:0]  digit;
    logic        valid;
    logic [31:0] period;
    logic        code, seq, tim, locked, newd;
  } vec_t;

  function automatic vec_t mk(logic [7:0] seg, int hold, logic clr, logic [3:0] digit,
                              logic valid, int period, logic code, logic seq, logic tim,
                              logic locked, logic newd);
    vec_t r;
    r.seg = seg; r.hold = hold; r.clr = clr; r.digit = digit; r.valid = valid;
    r.period = 32'(period); r.code = code; r.seq = seq; r.tim = tim;
    r.locked = locked; r.newd = newd;
    return r;
  endfunction

  vec_t vecs [31];

  initial begin : main
    int pulses, pulse_tick, r, hold_n, cur_d;
    logic [7:0] cur, nxt, g;
    bit clr_first;

    mon.SEG_IN  = 8'h00;
    mon.CLR_ERR = 1'b0;

    vecs[0] = mk(8'h3F, 100, 0, 4'h0, 1, 0, 0, 0, 0, 0, 1);
    for (int d = 1; d <= 17; d++)
      vecs[d] = mk(seg_tab[d % 16], 100, 0, 4'(d % 16), 1, 100, 0, 0, 0, d >= 2, 1);
    vecs[18] = mk(8'h4F, 100, 0, 4'h3, 1, 100, 0, 1, 0, 0, 1);
    vecs[19] = mk(8'h66, 100, 1, 4'h4, 1, 100, 0, 0, 0, 0, 1);
    vecs[20] = mk(8'h6D, 100, 0, 4'h5, 1, 100, 0, 0, 0, 1, 1);
    vecs[21] = mk(8'h7D, 103, 0, 4'h6, 1, 100, 0, 0, 0, 1, 1);
    vecs[22] = mk(8'h27,  97, 0, 4'h7, 1, 103, 0, 0, 1, 0, 1);
    vecs[23] = mk(8'h7F, 100, 0, 4'h8, 1,  97, 0, 0, 1, 0, 1);
    vecs[24] = mk(8'h6F, 100, 1, 4'h9, 1, 100, 0, 0, 0, 0, 1);
    vecs[25] = mk(8'h77, 100, 0, 4'hA, 1, 100, 0, 0, 0, 1, 1);
    vecs[26] = mk(8'hBF, 100, 0, 4'hA, 0, 100, 1, 0, 0, 0, 1);
    vecs[27] = mk(8'h7C, 100, 0, 4'hB, 1, 100, 1, 0, 0, 0, 1);
    vecs[28] = mk(8'h39, 100, 0, 4'hC, 1, 100, 1, 0, 0, 0, 1);
    vecs[29] = mk(8'h5E, 100, 1, 4'hD, 1, 100, 0, 0, 0, 1, 1);
    vecs[30] = mk(8'h5E,  20, 0, 4'hD, 1, 100, 0, 0, 1, 0, 0);

    do_reset();
    chk("reset state", outs(), 64'd0);
    tick(8'h00, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      pulses = 0;
      pulse_tick = -1;
      for (int t = 1; t <= vecs[i].hold; t++) begin
        tick(vecs[i].seg, (t == 1) ? vecs[i].clr : 1'b0, 1'b0);
        if (mon.NEW_DIGIT) begin
          pulses++;
          pulse_tick = t;
        end
      end
      chk($sformatf("vec%0d new_digit count", i), 64'(pulses), 64'(vecs[i].newd));
      if (vecs[i].newd)
        chk($sformatf("vec%0d new_digit latency", i), 64'(pulse_tick), 64'(LATENCY));
      chk($sformatf("vec%0d digit/valid", i), 64'({mon.DIGIT, mon.DIGIT_VALID}),
          64'({vecs[i].digit, vecs[i].valid}));
      chk($sformatf("vec%0d period", i), 64'(mon.PERIOD), 64'(vecs[i].period));
      chk($sformatf("vec%0d flags", i),
          64'({mon.CODE_ERR, mon.SEQ_ERR, mon.TIMING_ERR, mon.LOCKED}),
          64'({vecs[i].code, vecs[i].seq, vecs[i].tim, vecs[i].locked}));
    end

    // Glitch shorter than the filter inside a held pattern, then reset mid-period.
    do_reset();
    hold(8'h06, 50);
    pulses = 0;
    for (int t = 0; t < 3; t++) begin
      tick(8'h7F, 1'b0, 1'b0);
      if (mon.NEW_DIGIT) pulses++;
    end
    for (int t = 0; t < 20; t++) begin
      tick(8'h06, 1'b0, 1'b0);
      if (mon.NEW_DIGIT) pulses++;
    end
    chk("glitch new_digit count", 64'(pulses), 64'd0);
    chk("glitch digit", 64'({mon.DIGIT, mon.DIGIT_VALID}), 64'({4'h1, 1'b1}));
    tick(8'h06, 1'b0, 1'b1);
    chk("reset mid-period", outs(), 64'd0);

    // Timeout: exactly at counter PER_TMO, once per period, state kept afterwards.
    do_reset();
    hold(8'h06, 100);
    for (int t = 1; t <= 130; t++) begin
      tick(8'h5B, (t == 115) ? 1'b1 : 1'b0, 1'b0);
      if (t == LATENCY + PER_TMO - 1) chk("timeout not early", 64'(mon.TIMING_ERR), 64'd0);
      if (t == LATENCY + PER_TMO) chk("timeout set", 64'({mon.TIMING_ERR, mon.LOCKED}), 64'b10);
    end
    chk("timeout once per period", 64'(mon.TIMING_ERR), 64'd0);
    hold(8'h4F, 10);
    chk("late step still tracked", 64'({mon.DIGIT, mon.TIMING_ERR, mon.SEQ_ERR}),
        64'({4'h3, 1'b1, 1'b0}));

    // CLR_ERR in the same cycle as a new error leaves the flag set.
    do_reset();
    hold(8'h3F, 100);
    for (int t = 1; t <= 10; t++) tick(8'h4F, (t == LATENCY) ? 1'b1 : 1'b0, 1'b0);
    chk("clear vs new error", 64'({mon.SEQ_ERR, mon.DIGIT}), 64'({1'b1, 4'h3}));

`ifdef SEG7_MON_MINMAX_EN
    do_reset();
    hold(8'h3F, 99);
    hold(8'h06, 101);
    hold(8'h5B, 100);
    hold(8'h4F, 10);
    chk("period min/max", {mon.PERIOD_MIN, mon.PERIOD_MAX}, {32'd99, 32'd101});
    tick(8'h4F, 1'b1, 1'b0);
    chk("min/max cleared", {mon.PERIOD_MIN, mon.PERIOD_MAX}, {32'hFFFF_FFFF, 32'd0});
`endif

    // Randomised traffic, checked every cycle by the model.
    do_reset();
    cur = 8'h00;
    cur_d = 15;
    for (int s = 0; s < 220; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        tick(cur, 1'b0, 1'b1);
        continue;
      end
      hold_n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 12))
                                            : int'($urandom_range(95, 106));
      if (r < 72) begin
        cur_d = (cur_d + 1) % 16;
        nxt = seg_tab[cur_d];
      end else if (r < 82) begin
        cur_d = int'($urandom_range(0, 15));
        nxt = seg_tab[cur_d];
      end else if (r < 87) begin
        nxt = 8'($urandom_range(0, 255));
      end else if (r < 96) begin
        g = seg_tab[$urandom_range(0, 15)];
        repeat ($urandom_range(1, 3)) tick(g, 1'b0, 1'b0);
        nxt = cur;
      end else begin
        nxt = cur;
      end
      clr_first = ($urandom_range(0, 19) == 0);
      for (int t = 0; t < hold_n; t++) tick(nxt, (t == 0) ? clr_first : 1'b0, 1'b0);
      cur = nxt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_monitor.md
Name: seg7_monitor

Overview:
Receive-side checker for the 8-bit seven-segment bus that the 1 Hz hex-counter display driver produces. It synchronises and glitch-filters the pattern, then decodes it back to a hex digit. It measures the cycle count between digit changes and flags bad codes, out-of-sequence digits and out-of-tolerance periods. It sits on the board next to the display driver, or in a self-check bench, with its outputs marked for debug capture.

Parameters:
CLK_FREQ, 125_000_000, expected CLK cycles per digit step
TOL, 1000, allowed deviation in cycles, applied as plus or minus TOL around CLK_FREQ
STABLE_CYC, 8, consecutive cycles a synchronised pattern must hold before it is accepted (minimum 1)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
SEG_IN  input  8  segment bus; bit7 = dp, bits6..0 = g..a, active-high
CLR_ERR  input  1  clears all sticky error flags
DIGIT  output  4  last accepted decoded digit
DIGIT_VALID  output  1  DIGIT holds a legal decode
NEW_DIGIT  output  1  one-cycle pulse on each accepted pattern change
PERIOD  output  32  cycles between the last two NEW_DIGIT pulses
CODE_ERR  output  1  sticky: accepted pattern is not a legal code
SEQ_ERR  output  1  sticky: digit is not previous+1 mod 16
TIMING_ERR  output  1  sticky: period is out of tolerance, or timeout
LOCKED  output  1  two consecutive good steps have been seen

Behaviour:
- Reset: DIGIT=0, DIGIT_VALID=0, NEW_DIGIT=0, PERIOD=0, all error flags=0, LOCKED=0, state=IDLE. The synchroniser and filter are cleared to 8'h00. Reset mid-operation aborts any measurement.
- Input path: 2-flop synchroniser, then filter. A candidate pattern that differs from the accepted pattern is accepted after STABLE_CYC consecutive identical samples. Any change in the candidate restarts the filter count. Latency from a clean SEG_IN change to NEW_DIGIT is 2+STABLE_CYC cycles.
- Re-appearance of the currently accepted pattern is not an event.
- Decode table, bit7 = 0 required: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 27=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
- Illegal code (any other value, or bit7=1) on acceptance:
  - NEW_DIGIT pulses; CODE_ERR is set.
  - DIGIT_VALID=0 and DIGIT holds its old value.
  - LOCKED=0 and state goes to IDLE.
- Period counter: 32-bit, saturating at 32'hFFFF_FFFF. PERIOD equals t1-t0 for consecutive accepted legal changes at cycles t0 and t1. PERIOD updates in the same cycle as NEW_DIGIT.
- FSM states:
  - IDLE: a legal accept loads DIGIT, sets DIGIT_VALID=1 and starts the counter. Next state ARMED.
  - ARMED: a legal accept updates PERIOD and runs the checks. Next state TRACK.
  - TRACK: a legal accept updates PERIOD and runs the checks. State stays TRACK.
- Checks in ARMED and TRACK:
  - SEQ_ERR if new digit != (DIGIT+1) mod 16. F to 0 is legal.
  - TIMING_ERR if PERIOD < CLK_FREQ-TOL or PERIOD > CLK_FREQ+TOL.
- Timeout: in ARMED or TRACK, TIMING_ERR is set when the counter reaches CLK_FREQ+TOL+1 without an accept. The flag is set once per period and the state is kept.
- LOCKED:
  - Set after two consecutive error-free steps in ARMED/TRACK.
  - Cleared on any new error or on a return to IDLE.
  - CLR_ERR does not set LOCKED.
- Errors are sticky until CLR_ERR or RST. If CLR_ERR and a new error occur in the same cycle, the flag ends set.
- All outputs are registered; there are no combinational paths from input to output.

Optional Feature:
Macro SEG7_MON_MINMAX_EN.
- Defined:
  - Adds outputs PERIOD_MIN[31:0] (reset 32'hFFFF_FFFF) and PERIOD_MAX[31:0] (reset 0).
  - Both update in the same cycle as PERIOD, for every measured period in ARMED/TRACK.
  - CLR_ERR also re-initialises both to their reset values.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
Use CLK_FREQ=100, TOL=2, STABLE_CYC=4.
- Drive 3F,06,5B,4F, each held 100 cycles -> NEW_DIGIT 6 cycles after each change; PERIOD=100; no errors; LOCKED rises at the third accept.
- Drive 71 then 3F, 100 cycles apart (F to 0 wrap) -> DIGIT=0; SEQ_ERR=0.
- Drive 06 then 4F -> SEQ_ERR=1 and LOCKED=0. Pulse CLR_ERR -> SEQ_ERR=0.
- Drive a 3-cycle glitch 7F inside a held 06 -> no NEW_DIGIT; DIGIT unchanged.
- Hold 5B for 103 cycles after a legal step -> TIMING_ERR set at counter=103. Hold for 97 cycles -> TIMING_ERR on accept with PERIOD=97. Drive 8'hBF -> CODE_ERR=1, DIGIT_VALID=0, state IDLE.
- Assert RST mid-period -> all outputs return to their reset values the next cycle. With SEG7_MON_MINMAX_EN, periods 99,101,100 -> PERIOD_MIN=99, PERIOD_MAX=101.
